// File: rtl/lfu_cache_array.sv
// lfu_cache_array
//   LFU cache data array. Stores the cache lines together with a valid bit and
//   a saturating use counter for each line. A scan FSM picks the exact victim:
//   the first invalid line, otherwise the lowest-count line, with ties going to
//   the lowest index. An aging pass halves every counter.
//
// Ports
//   clk           rising-edge clock
//   gen_reset     synchronous active-high reset (clears valid/cnt, not data)
//   wr_en         write strobe
//   wr_src_ram    1 = full-line fill from RAM, 0 = CPU word write
//   wr_word_sel   CPU word slot within the line
//   rd_en         read strobe (read-first against a same-cycle write)
//   addr          line index for read/write
//   data_in       fill data; CPU word in [WORD_BITS-1:0]
//   data_out      registered read data
//   rd_valid      1-cycle pulse, data_out valid
//   victim_req    start victim scan (IDLE only, wins over age_req)
//   age_req       start aging pass (IDLE only)
//   busy          FSM not idle
//   victim_valid  1-cycle pulse, victim result valid
//   victim_addr   selected line
//   victim_count  counter of selected line (0 if the line was invalid)
module lfu_cache_array #(
  parameter int ADDR_BITS = 10,
  parameter int LINE_BITS = 64,
  parameter int WORD_BITS = 16,
  parameter int CNT_BITS  = 4
) (
  input  logic                                     clk,
  input  logic                                     gen_reset,
  input  logic                                     wr_en,
  input  logic                                     wr_src_ram,
  input  logic [$clog2(LINE_BITS/WORD_BITS)-1:0]   wr_word_sel,
  input  logic                                     rd_en,
  input  logic [ADDR_BITS-1:0]                     addr,
  input  logic [LINE_BITS-1:0]                     data_in,
  output logic [LINE_BITS-1:0]                     data_out,
  output logic                                     rd_valid,
  input  logic                                     victim_req,
  input  logic                                     age_req,
  output logic                                     busy,
  output logic                                     victim_valid,
  output logic [ADDR_BITS-1:0]                     victim_addr,
  output logic [CNT_BITS-1:0]                      victim_count
);

  localparam int unsigned N = 2**ADDR_BITS;
  localparam logic [CNT_BITS-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE,
    ST_AGE
  } state_t;

  logic [LINE_BITS-1:0] r_mem   [N];
  logic                 r_valid [N];
  logic [CNT_BITS-1:0]  r_cnt   [N];

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [ADDR_BITS-1:0] r_best_addr;
  logic [CNT_BITS-1:0]  r_best_cnt;

  logic [LINE_BITS-1:0] r_data_out;
  logic                 r_rd_valid;
  logic                 r_busy;
  logic                 r_victim_valid;
  logic [ADDR_BITS-1:0] r_victim_addr;
  logic [CNT_BITS-1:0]  r_victim_count;

  logic                 w_fill;
  logic                 w_cpu_wr;
  logic                 w_access;
  logic                 w_aging;
  logic                 w_age_hit;
  logic [CNT_BITS-1:0]  w_cnt_base;
  logic [CNT_BITS-1:0]  w_cnt_next;
  logic                 w_insp_valid;
  logic [CNT_BITS-1:0]  w_insp_cnt;
  logic                 w_last;
  logic                 w_take;
  logic [ADDR_BITS-1:0] w_new_best_addr;
  logic [CNT_BITS-1:0]  w_new_best_cnt;

  assign data_out     = r_data_out;
  assign rd_valid     = r_rd_valid;
  assign busy         = r_busy;
  assign victim_valid = r_victim_valid;
  assign victim_addr  = r_victim_addr;
  assign victim_count = r_victim_count;

  always_comb begin
    w_fill    = wr_en & wr_src_ram;
    w_cpu_wr  = wr_en & ~wr_src_ram;
    w_access  = rd_en | wr_en;
    w_aging   = (r_state == ST_AGE);
    w_age_hit = w_aging && (r_ptr == addr);
    // An access landing on the line being aged builds on the halved value.
    w_cnt_base = w_age_hit ? (r_cnt[addr] >> 1) : r_cnt[addr];
    if (w_fill)
      w_cnt_next = CNT_BITS'(1);
    else if (w_cnt_base == CMAX)
      w_cnt_next = CMAX;
    else
      w_cnt_next = w_cnt_base + CNT_BITS'(1);

    w_insp_valid    = r_valid[r_ptr];
    w_insp_cnt      = r_cnt[r_ptr];
    w_last          = &r_ptr;
    // Strict less-than keeps the lowest index on ties.
    w_take          = (r_ptr == '0) || (w_insp_cnt < r_best_cnt);
    w_new_best_addr = w_take ? r_ptr : r_best_addr;
    w_new_best_cnt  = w_take ? w_insp_cnt : r_best_cnt;
  end

  // Line data: not reset.
  always_ff @(posedge clk) begin
    if (w_fill)
      r_mem[addr] <= data_in;
    else if (w_cpu_wr)
      r_mem[addr][wr_word_sel*WORD_BITS +: WORD_BITS] <= data_in[WORD_BITS-1:0];
  end

  // Registered read port, read-first.
  always_ff @(posedge clk) begin
    if (gen_reset) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en)
        r_data_out <= r_mem[addr];
    end
  end

  // Valid bits and use counters. When aging and an access hit the same line,
  // the second assignment wins and already carries the halving.
  always_ff @(posedge clk) begin
    if (gen_reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= '0;
      end
    end else begin
      if (w_aging)
        r_cnt[r_ptr] <= r_cnt[r_ptr] >> 1;
      if (w_access)
        r_cnt[addr] <= w_cnt_next;
      if (w_fill)
        r_valid[addr] <= 1'b1;
    end
  end

  // Scan / aging FSM. ST_DONE holds busy for the cycle carrying the victim pulse.
  always_ff @(posedge clk) begin
    if (gen_reset) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_best_addr    <= '0;
      r_best_cnt     <= '0;
      r_busy         <= 1'b0;
      r_victim_valid <= 1'b0;
      r_victim_addr  <= '0;
      r_victim_count <= '0;
    end else begin
      r_victim_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ptr <= '0;
          if (victim_req) begin
            r_state <= ST_SCAN;
            r_busy  <= 1'b1;
          end else if (age_req) begin
            r_state <= ST_AGE;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!w_insp_valid) begin
            r_victim_addr  <= r_ptr;
            r_victim_count <= '0;
            r_victim_valid <= 1'b1;
            r_state        <= ST_DONE;
          end else if (w_last) begin
            r_victim_addr  <= w_new_best_addr;
            r_victim_count <= w_new_best_cnt;
            r_victim_valid <= 1'b1;
            r_state        <= ST_DONE;
          end else begin
            r_best_addr <= w_new_best_addr;
            r_best_cnt  <= w_new_best_cnt;
            r_ptr       <= r_ptr + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        ST_AGE: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfu_cache_array.sv
module tb_lfu_cache_array;

  localparam int AB = 4;
  localparam int LB = 64;
  localparam int WB = 16;
  localparam int CB = 4;
  localparam int N  = 16;

  localparam int MD_IDLE = 0;
  localparam int MD_SCAN = 1;
  localparam int MD_HOLD = 2;
  localparam int MD_AGE  = 3;

  logic          clk = 1'b0;
  logic          gen_reset;
  logic          wr_en;
  logic          wr_src_ram;
  logic [1:0]    wr_word_sel;
  logic          rd_en;
  logic [AB-1:0] addr;
  logic [LB-1:0] data_in;
  logic [LB-1:0] data_out;
  logic          rd_valid;
  logic          victim_req;
  logic          age_req;
  logic          busy;
  logic          victim_valid;
  logic [AB-1:0] victim_addr;
  logic [CB-1:0] victim_count;

  always #5 clk = ~clk;

  lfu_cache_array #(
    .ADDR_BITS(AB),
    .LINE_BITS(LB),
    .WORD_BITS(WB),
    .CNT_BITS (CB)
  ) dut (
    .clk         (clk),
    .gen_reset   (gen_reset),
    .wr_en       (wr_en),
    .wr_src_ram  (wr_src_ram),
    .wr_word_sel (wr_word_sel),
    .rd_en       (rd_en),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .victim_req  (victim_req),
    .age_req     (age_req),
    .busy        (busy),
    .victim_valid(victim_valid),
    .victim_addr (victim_addr),
    .victim_count(victim_count)
  );

  // Reference model
  logic [63:0] m_mem [N];
  bit          m_val [N];
  int          m_cnt [N];
  int          m_mode = MD_IDLE;
  int          m_idx  = 0;
  bit          s_val [N];
  int          s_cnt [N];

  logic [63:0] e_data  = '0;
  logic        e_rv    = 1'b0;
  logic        e_busy  = 1'b0;
  logic        e_vv    = 1'b0;
  int          e_vaddr = 0;
  int          e_vcnt  = 0;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int req_edge = 0;
  int pulse_cnt = 0;
  int last_pulse_edge = 0;
  int busy_seen = 0;
  int obs_vaddr = 0;
  int obs_vcnt = 0;

  function automatic int sat_inc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  // Victim from the snapshots taken as each line was inspected.
  function automatic void finish_scan(input int last);
    int best_a;
    int best_c;
    best_a = 0;
    best_c = 1000;
    for (int j = 0; j <= last; j++) begin
      if (!s_val[j]) begin
        best_a = j;
        best_c = 0;
        break;
      end
      if (s_cnt[j] < best_c) begin
        best_a = j;
        best_c = s_cnt[j];
      end
    end
    e_vv    = 1'b1;
    e_vaddr = best_a;
    e_vcnt  = best_c;
  endfunction

  function automatic void model_edge();
    bit          was_idle;
    logic [63:0] tmp;
    int          a;
    if (gen_reset) begin
      for (int i = 0; i < N; i++) begin
        m_val[i] = 1'b0;
        m_cnt[i] = 0;
      end
      m_mode = MD_IDLE;
      e_data = '0; e_rv = 1'b0; e_busy = 1'b0; e_vv = 1'b0; e_vaddr = 0; e_vcnt = 0;
      return;
    end
    a = int'(addr);
    was_idle = (m_mode == MD_IDLE);
    e_vv = 1'b0;
    if (m_mode == MD_SCAN) begin
      s_val[m_idx] = m_val[m_idx];
      s_cnt[m_idx] = m_cnt[m_idx];
      if (!m_val[m_idx] || m_idx == N - 1) begin
        finish_scan(m_idx);
        m_mode = MD_HOLD;
      end else begin
        m_idx++;
      end
    end else if (m_mode == MD_HOLD) begin
      m_mode = MD_IDLE;
    end else if (m_mode == MD_AGE) begin
      m_cnt[m_idx] = m_cnt[m_idx] / 2;
      m_idx++;
      if (m_idx == N) m_mode = MD_IDLE;
    end
    e_rv = rd_en;
    if (rd_en) e_data = m_mem[a];
    if (wr_en && wr_src_ram) begin
      m_mem[a] = data_in;
      m_val[a] = 1'b1;
      m_cnt[a] = 1;
    end else if (wr_en) begin
      tmp = m_mem[a];
      tmp[int'(wr_word_sel)*16 +: 16] = data_in[15:0];
      m_mem[a] = tmp;
      m_cnt[a] = sat_inc(m_cnt[a]);
    end else if (rd_en) begin
      m_cnt[a] = sat_inc(m_cnt[a]);
    end
    if (was_idle) begin
      if (victim_req) begin
        m_mode = MD_SCAN;
        m_idx  = 0;
      end else if (age_req) begin
        m_mode = MD_AGE;
        m_idx  = 0;
      end
    end
    e_busy = (m_mode != MD_IDLE);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    edge_no++;
    #1;
    if (busy === 1'b1) busy_seen++;
    if (victim_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_edge = edge_no;
      obs_vaddr = int'(victim_addr);
      obs_vcnt  = int'(victim_count);
    end
    chk("rd_valid", rd_valid, e_rv);
    chk("data_out", data_out, e_data);
    chk("busy", busy, e_busy);
    chk("victim_valid", victim_valid, e_vv);
    chk("victim_addr", victim_addr, e_vaddr);
    chk("victim_count", victim_count, e_vcnt);
  endtask

  task automatic idle_in();
    gen_reset = 1'b0; wr_en = 1'b0; wr_src_ram = 1'b0; wr_word_sel = '0;
    rd_en = 1'b0; victim_req = 1'b0; age_req = 1'b0;
  endtask

  task automatic fill(input int a, input logic [63:0] d);
    wr_en = 1'b1; wr_src_ram = 1'b1; addr = AB'(a); data_in = d;
    tick();
    idle_in();
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1; addr = AB'(a);
    tick();
    idle_in();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_mode != MD_IDLE && k < 40) begin
      tick();
      k++;
    end
    chk("drain_timeout", (k < 40), 1'b1);
  endtask

  task automatic do_scan();
    victim_req = 1'b1;
    req_edge = edge_no + 1;
    tick();
    victim_req = 1'b0;
    drain();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int b0;
    addr = '0; data_in = '0;
    idle_in();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0; m_val[i] = 1'b0; m_cnt[i] = 0;
    end

    // Reset state
    gen_reset = 1'b1;
    tick();
    tick();
    gen_reset = 1'b0;

    // 1: empty array, victim is line 0 on the first inspected line
    p0 = pulse_cnt; b0 = busy_seen;
    do_scan();
    chk("t1_pulses", pulse_cnt - p0, 1);
    chk("t1_latency", last_pulse_edge - req_edge, 1);
    chk("t1_addr", obs_vaddr, 0);
    chk("t1_count", obs_vcnt, 0);
    chk("t1_busy_cycles", busy_seen - b0, 2);

    // 2: full scan, tie among 1..15 goes to line 1
    for (int a = 0; a < N; a++) fill(a, rnd64());
    rd(0); rd(0); rd(3);
    p0 = pulse_cnt;
    do_scan();
    chk("t2_pulses", pulse_cnt - p0, 1);
    chk("t2_latency", last_pulse_edge - req_edge, 16);
    chk("t2_addr", obs_vaddr, 1);
    chk("t2_count", obs_vcnt, 1);

    // 3: counter saturation and refill reset to 1
    fill(2, rnd64());
    repeat (20) rd(2);
    for (int a = 0; a < N; a++) if (a != 2) repeat (16) rd(a);
    do_scan();
    chk("t3_sat_addr", obs_vaddr, 0);
    chk("t3_sat_count", obs_vcnt, 15);
    fill(2, rnd64());
    do_scan();
    chk("t3_refill_addr", obs_vaddr, 2);
    chk("t3_refill_count", obs_vcnt, 1);

    // 4: aging, with a read landing on line 5 during its aging cycle
    fill(6, rnd64()); rd(6); rd(6);
    fill(2, rnd64()); repeat (14) rd(2);
    b0 = busy_seen;
    age_req = 1'b1;
    tick();
    age_req = 1'b0;
    repeat (5) tick();
    rd(5);
    drain();
    chk("t4_busy_cycles", busy_seen - b0, 16);
    do_scan();
    chk("t4_min_addr", obs_vaddr, 6);
    chk("t4_min_count", obs_vcnt, 1);
    for (int a = 0; a < N; a++) if (a != 5) repeat (2) rd(a);
    repeat (6) rd(6);
    do_scan();
    chk("t4_aged_hit_addr", obs_vaddr, 5);
    chk("t4_aged_hit_count", obs_vcnt, 8);

    // 5: CPU word write with same-cycle read is read-first
    fill(7, 64'h0);
    wr_en = 1'b1; wr_src_ram = 1'b0; wr_word_sel = 2'd2; rd_en = 1'b1;
    addr = AB'(7); data_in = 64'h1234_5678_9ABC_BEEF;
    tick();
    idle_in();
    chk("t5_readfirst", data_out, 64'h0);
    rd(7);
    chk("t5_word", data_out, 64'h0000_BEEF_0000_0000);

    // 6: reset in cycle 5 of a full scan aborts it
    p0 = pulse_cnt;
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    repeat (4) tick();
    gen_reset = 1'b1;
    tick();
    gen_reset = 1'b0;
    chk("t6_busy_after_reset", busy, 1'b0);
    repeat (20) tick();
    chk("t6_no_pulse", pulse_cnt - p0, 0);
    do_scan();
    chk("t6_addr", obs_vaddr, 0);
    chk("t6_count", obs_vcnt, 0);
    chk("t6_latency", last_pulse_edge - req_edge, 1);

    // Randomized traffic, including requests while busy
    for (int a = 0; a < N; a++) fill(a, rnd64());
    repeat (600) begin
      addr        = AB'($urandom_range(0, N - 1));
      data_in     = rnd64();
      wr_word_sel = 2'($urandom_range(0, 3));
      wr_src_ram  = $urandom_range(0, 1) == 1;
      wr_en       = $urandom_range(0, 2) == 0;
      rd_en       = $urandom_range(0, 1) == 1;
      victim_req  = $urandom_range(0, 7) == 0;
      age_req     = $urandom_range(0, 15) == 0;
      tick();
    end
    idle_in();
    drain();
    do_scan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
